// File: rtl/writeback_stage_if.sv
// writeback_stage_if: execution-result input and register-file write port of the writeback stage
// master drives inValid/inResult/inCarry/inDest/inCarryWrite and regWriteReady;
// slave (the stage) drives inReady, regWriteEn, regWriteAddr and regWriteData.
interface writeback_stage_if #(
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA = 8,
  parameter int BITS_REG = 4
);
  logic inValid;
  logic inReady;
  logic [BITS_ARRAY-1:0] inResult;
  logic [BITS_DATA-1:0] inCarry;
  logic [BITS_REG-1:0] inDest;
  logic inCarryWrite;
  logic regWriteEn;
  logic regWriteReady;
  logic [BITS_REG-1:0] regWriteAddr;
  logic [BITS_ARRAY-1:0] regWriteData;
  modport master (
    output inValid, inResult, inCarry, inDest, inCarryWrite, regWriteReady,
    input inReady, regWriteEn, regWriteAddr, regWriteData
  );
  modport slave (
    input inValid, inResult, inCarry, inDest, inCarryWrite, regWriteReady,
    output inReady, regWriteEn, regWriteAddr, regWriteData
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: 2-entry result FIFO to the register-file write port plus lane carry feedback register
// Ports: clk, rst_n (async active-low), wb (slave: exec result in, regfile write out),
// carryClear (sync carry clear), auxCarryOut (bit-reversed stored carries), commitCount (writes done).
// Macro CARRY_CHAIN_EN enables the carry register; when undefined auxCarryOut is 0.
module writeback_stage #(
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA = 8,
  parameter int BITS_REG = 4
) (
  input  logic clk,
  input  logic rst_n,
  writeback_stage_if.slave wb,
  input  logic carryClear,
  output logic [BITS_DATA-1:0] auxCarryOut,
  output logic [15:0] commitCount
);
  logic [BITS_REG+BITS_ARRAY-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic accept, push, pop;
  assign wb.inReady = count != 2'd2;
  assign wb.regWriteEn = count != 2'd0;
  assign accept = wb.inValid && wb.inReady;
  assign push = accept && wb.inDest != '0;
  assign pop = wb.regWriteEn && wb.regWriteReady;
  // Output registers track the head so they hold their last value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
      commitCount <= 16'd0;
      {wb.regWriteAddr, wb.regWriteData} <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (pop) commitCount <= commitCount + 16'd1;
      count <= count + 2'(push) - 2'(pop);
      if (pop && count == 2'd2) {wb.regWriteAddr, wb.regWriteData} <= mem[~rd_ptr];
      else if (push && (count == 2'd0 || pop)) {wb.regWriteAddr, wb.regWriteData} <= {wb.inDest, wb.inResult};
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {wb.inDest, wb.inResult};
`ifdef CARRY_CHAIN_EN
  logic [BITS_DATA-1:0] carry_rev;
  // Lane 0's carry lands in the MSB, where the execution stage expects it.
  for (genvar i = 0; i < BITS_DATA; i++) begin : g_rev
    assign carry_rev[BITS_DATA-1-i] = wb.inCarry[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) auxCarryOut <= '0;
    else auxCarryOut <= carryClear ? '0 : (accept && wb.inCarryWrite) ? carry_rev : auxCarryOut;
`else
  logic unused_carry;
  assign unused_carry = ^{carryClear, wb.inCarry, wb.inCarryWrite};
  assign auxCarryOut = '0;
`endif
endmodule
